// File: rtl/apb_processor_request_sequencer.sv
// Processor-side request sequencer: queues CPU transfer requests in a small
// FIFO and plays them onto the processor bus of the APB master one at a time,
// returning read data or a timeout error for each completed request.
module apb_processor_request_sequencer #(
  parameter int DEPTH   = 4,   // power of 2, >= 2
  parameter int TIMEOUT = 64   // >= 2, WAIT cycles allowed before abort
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  // request side
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_sel,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  // processor bus towards the APB master
  output logic       p_start,
  output logic       p_write,
  output logic [1:0] p_sel,
  output logic [7:0] p_addr,
  output logic [7:0] p_wdata,
  input  logic       p_stable,
  input  logic [7:0] p_rdata,
  // response side
  output logic       rsp_valid,
  output logic       rsp_write,
  output logic [7:0] rsp_addr,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_e;

  typedef struct packed {
    logic       write;
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  req_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Sequencer state, holding register and registered outputs
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  req_t          hold_q, hold_d;
  logic          p_start_q, p_start_d;
  logic [1:0]    p_sel_q, p_sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_write_q, rsp_write_d;
  logic [7:0]    rsp_addr_q, rsp_addr_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          rsp_error_q, rsp_error_d;

  logic full, empty, push, pop;
  req_t head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // req_ready only looks at fullness, never at a same-cycle pop; a request
  // with sel==0 is handshaken but never written.
  assign req_ready = !full;
  assign push      = req_valid && !full && (req_sel != 2'd0);
  assign pop       = (state_q == S_IDLE) && !empty;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  assign p_start   = p_start_q;
  assign p_sel     = p_sel_q;
  assign p_write   = hold_q.write;
  assign p_addr    = hold_q.addr;
  assign p_wdata   = hold_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign busy      = (state_q != S_IDLE) || !empty;

  // FIFO write port
  // NOTE: the storage array carries no reset; the pointers alone define which
  // entries are valid, so resetting the data would only cost reset routing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {req_write, req_sel, req_addr, req_wdata};
    end
  end

  // Next-state and next-output logic for the pointers and the sequencer
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // this block leaves a value unassigned, which would infer a latch.
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    state_d     = state_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    p_start_d   = 1'b0;
    p_sel_d     = p_sel_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          hold_d    = head;
          p_sel_d   = head.sel;
          p_start_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // p_stable is deliberately ignored here: it may still be high from
        // the previous transfer.
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (p_stable) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = hold_q.write;
          rsp_addr_d  = hold_q.addr;
          rsp_rdata_d = hold_q.write ? 8'h00 : p_rdata;
          rsp_error_d = 1'b0;
          state_d     = S_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = hold_q.write;
          rsp_addr_d  = hold_q.addr;
          rsp_rdata_d = 8'h00;
          rsp_error_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        // Dropping sel for one cycle lets the APB master fall back to idle.
        p_sel_d = 2'd0;
        state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer, pointer and output registers
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      hold_q      <= '0;
      p_start_q   <= 1'b0;
      p_sel_q     <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_addr_q  <= 8'h00;
      rsp_rdata_q <= 8'h00;
      rsp_error_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      p_start_q   <= p_start_d;
      p_sel_q     <= p_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule
